// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_cmd_t  : one-hot-free encoding of the command executed in a cycle
//   pc_decode : fixed-priority encoder over the six command strobes
//               (clear > load > call > ret > branch > up)
package pc_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET,
    CMD_BRANCH,
    CMD_UP
  } pc_cmd_t;

  function automatic pc_cmd_t pc_decode(input logic clear, input logic load,
                                        input logic call, input logic ret,
                                        input logic branch, input logic up);
    pc_cmd_t cmd;
    if (clear)       cmd = CMD_CLEAR;
    else if (load)   cmd = CMD_LOAD;
    else if (call)   cmd = CMD_CALL;
    else if (ret)    cmd = CMD_RET;
    else if (branch) cmd = CMD_BRANCH;
    else if (up)     cmd = CMD_UP;
    else             cmd = CMD_NONE;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the program-counter sequencer.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset (clears pointer)
//   push, pop, flush  : at most one asserted per cycle by the caller
//   push_data         : return address to store on push
//   top               : registered copy of the newest entry (valid when !empty)
//   full, empty       : occupancy flags derived from the stack pointer
//   fault             : combinational pulse on push-when-full or pop-when-empty
module pc_return_stack #(
  parameter int ADDR_W      = 7,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic              fault
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   below;
  logic [ADDR_W-1:0] mem [0:(1<<IDX_W)-1];
  logic              do_push;
  logic              do_pop;

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign fault   = (push && full) || (pop && empty);
  // Slot that becomes the new top after a pop.
  assign below   = sp - SP_W'(2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     sp <= '0;
    else if (flush)   sp <= '0;
    else if (do_push) sp <= sp + SP_W'(1);
    else if (do_pop)  sp <= sp - SP_W'(1);
  end

  // Storage and the top-of-stack copy carry no reset: contents are
  // meaningless whenever the pointer says the stack is empty.  Keeping top
  // registered lets a ret immediately after a call see the pushed value.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (do_push) begin
        mem[sp[IDX_W-1:0]] <= push_data;
        top                <= push_data;
      end else if (do_pop) begin
        top <= mem[below[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter for the instruction-fetch path.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   clear               : synchronous equivalent of reset
//   load/call/ret/branch/up : command strobes, fixed priority in that order
//                         after clear
//   target              : load/call destination
//   offset              : signed branch displacement (wraps modulo 2^ADDR_W)
//   address             : current program counter (registered)
//   stack_full/empty    : return-stack occupancy
//   halted              : up reached max address with WRAP=0
//   err                 : sticky call-on-full / ret-on-empty indicator
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W      = 7,
  parameter int              STACK_DEPTH = 4,
  parameter bit              WRAP        = 1'b1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              up,
  input  logic              load,
  input  logic              call,
  input  logic              ret,
  input  logic              branch,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] address,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              halted,
  output logic              err
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

  pc_cmd_t           cmd;
  logic [ADDR_W-1:0] addend;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] address_nxt;
  logic              halted_nxt;
  logic              err_nxt;
  logic              fault;

  assign cmd = pc_decode(clear, load, call, ret, branch, up);

  // One adder serves branch (address+offset), increment and the call
  // return address (address+1).
  assign addend = (cmd == CMD_BRANCH) ? offset : ADDR_W'(1);
  assign sum    = address + addend;

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd == CMD_CALL),
    .pop       (cmd == CMD_RET),
    .flush     (cmd == CMD_CLEAR),
    .push_data (sum),
    .top       (top),
    .full      (stack_full),
    .empty     (stack_empty),
    .fault     (fault)
  );

  always_comb begin
    address_nxt = address;
    halted_nxt  = halted;
    err_nxt     = err | fault;
    case (cmd)
      CMD_CLEAR: begin
        address_nxt = RESET_ADDR;
        halted_nxt  = 1'b0;
        err_nxt     = 1'b0;
      end
      CMD_LOAD: begin
        address_nxt = target;
        halted_nxt  = 1'b0;
      end
      // A rejected call/ret leaves address and halted untouched.
      CMD_CALL: begin
        if (!stack_full) begin
          address_nxt = target;
          halted_nxt  = 1'b0;
        end
      end
      CMD_RET: begin
        if (!stack_empty) begin
          address_nxt = top;
          halted_nxt  = 1'b0;
        end
      end
      CMD_BRANCH: begin
        address_nxt = sum;
        halted_nxt  = 1'b0;
      end
      CMD_UP: begin
        if (!halted) begin
          if (address != MAX_ADDR) address_nxt = sum;
          else if (WRAP)           address_nxt = '0;
          else                     halted_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address <= RESET_ADDR;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      address <= address_nxt;
      halted  <= halted_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear, up, load, call, ret, branch;
  logic [AW-1:0] target, offset;

  logic [AW-1:0] addr_w, addr_s;
  logic          full_w, empty_w, halt_w, err_w;
  logic          full_s, empty_s, halt_s, err_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .WRAP(1'b1), .RESET_ADDR('0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .clear(clear), .up(up), .load(load), .call(call),
    .ret(ret), .branch(branch), .target(target), .offset(offset), .address(addr_w),
    .stack_full(full_w), .stack_empty(empty_w), .halted(halt_w), .err(err_w));

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .WRAP(1'b0), .RESET_ADDR('0)) dut_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .up(up), .load(load), .call(call),
    .ret(ret), .branch(branch), .target(target), .offset(offset), .address(addr_s),
    .stack_full(full_s), .stack_empty(empty_s), .halted(halt_s), .err(err_s));

  // Reference model: index 0 mirrors the wrapping instance, 1 the saturating one.
  int m_addr [2];
  bit m_halt [2];
  bit m_err  [2];
  int m_stk  [2][$];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 0;
      m_halt[i] = 0;
      m_err[i]  = 0;
      m_stk[i].delete();
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        m_addr[i] = 0; m_halt[i] = 0; m_err[i] = 0; m_stk[i].delete();
      end else if (load) begin
        m_addr[i] = int'(target); m_halt[i] = 0;
      end else if (call) begin
        if (m_stk[i].size() == DEPTH) m_err[i] = 1;
        else begin
          m_stk[i].push_back((m_addr[i] + 1) % MOD);
          m_addr[i] = int'(target); m_halt[i] = 0;
        end
      end else if (ret) begin
        if (m_stk[i].size() == 0) m_err[i] = 1;
        else begin
          m_addr[i] = m_stk[i].pop_back(); m_halt[i] = 0;
        end
      end else if (branch) begin
        m_addr[i] = (((m_addr[i] + int'($signed(offset))) % MOD) + MOD) % MOD;
        m_halt[i] = 0;
      end else if (up && !m_halt[i]) begin
        if (m_addr[i] < MOD - 1) m_addr[i] = m_addr[i] + 1;
        else if (i == 0)         m_addr[i] = 0;
        else                     m_halt[i] = 1;
      end
    end
  endfunction

  function automatic logic [AW+3:0] exp_vec(int i);
    return {AW'(m_addr[i]), m_stk[i].size() == DEPTH, m_stk[i].size() == 0, m_halt[i], m_err[i]};
  endfunction

  function automatic logic [AW+3:0] obs(int i);
    return (i == 0) ? {addr_w, full_w, empty_w, halt_w, err_w}
                    : {addr_s, full_s, empty_s, halt_s, err_s};
  endfunction

  task automatic set_cmd(input bit c, input bit l, input bit ca, input bit r,
                         input bit b, input bit u, input int t, input int o);
    clear = c; load = l; call = ca; ret = r; branch = b; up = u;
    target = AW'(t); offset = AW'(o);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_cmd(input bit c, input bit l, input bit ca, input bit r,
                        input bit b, input bit u, input int t, input int o);
    set_cmd(c, l, ca, r, b, u, t, o);
    step();
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 1, 0, 0);
    model_reset();
    #3;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== {AW'(0), 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h want %h", i, obs(i), {AW'(0), 4'b0100});
      end
    end
    @(posedge clk); #3;  // up held across an edge while in reset
    checks++;
    if (addr_w !== '0) begin
      errors++;
      $display("FAIL reset_blocks_up: got %0d want 0", addr_w);
    end
    reset_n = 1'b1;
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_up_wrap();
    do_cmd(1, 0, 0, 0, 0, 0, 0, 0);
    set_cmd(0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 130; k++) begin
      step();
      checks++;
      if (addr_w !== AW'(k % MOD) || halt_w !== 1'b0) begin
        errors++;
        $display("FAIL up_wrap k=%0d: got addr=%0d halted=%b want addr=%0d halted=0",
                 k, addr_w, halt_w, k % MOD);
      end
      checks++;
      if (obs(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL up_sat_model k=%0d: got %h want %h", k, obs(1), exp_vec(1));
      end
    end
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturate();
    int exp_a [4] = '{126, 127, 127, 127};
    bit exp_h [4] = '{0, 0, 1, 1};
    do_cmd(0, 1, 0, 0, 0, 0, 125, 0);
    checks++;
    if (addr_s !== AW'(125) || halt_s !== 1'b0) begin
      errors++;
      $display("FAIL sat_load: got addr=%0d halted=%b want 125/0", addr_s, halt_s);
    end
    for (int k = 0; k < 4; k++) begin
      do_cmd(0, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (addr_s !== AW'(exp_a[k]) || halt_s !== exp_h[k]) begin
        errors++;
        $display("FAIL sat_up%0d: got addr=%0d halted=%b want %0d/%b",
                 k, addr_s, halt_s, exp_a[k], exp_h[k]);
      end
    end
    do_cmd(0, 0, 0, 0, 1, 0, 0, -2);
    checks++;
    if (addr_s !== AW'(125) || halt_s !== 1'b0) begin
      errors++;
      $display("FAIL sat_branch_back: got addr=%0d halted=%b want 125/0", addr_s, halt_s);
    end
  endtask

  task automatic test_call_ret();
    int exp_a [4] = '{40, 60, 41, 11};
    do_cmd(1, 0, 0, 0, 0, 0, 0, 0);
    do_cmd(0, 1, 0, 0, 0, 0, 10, 0);
    for (int k = 0; k < 4; k++) begin
      if (k < 2) do_cmd(0, 0, 1, 0, 0, 0, exp_a[k], 0);
      else       do_cmd(0, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (addr_w !== AW'(exp_a[k])) begin
        errors++;
        $display("FAIL call_ret step%0d: got addr=%0d want %0d", k, addr_w, exp_a[k]);
      end
    end
    checks++;
    if (empty_w !== 1'b1 || err_w !== 1'b0) begin
      errors++;
      $display("FAIL call_ret_end: got empty=%b err=%b want 1/0", empty_w, err_w);
    end
  endtask

  task automatic test_overflow();
    do_cmd(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      do_cmd(0, 0, 1, 0, 0, 0, 20 + k, 0);
      checks++;
      if (obs(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL overflow_call%0d: got %h want %h", k, obs(0), exp_vec(0));
      end
    end
    checks++;
    if (full_w !== 1'b1 || addr_w !== AW'(23) || err_w !== 1'b1) begin
      errors++;
      $display("FAIL overflow_fifth: got full=%b addr=%0d err=%b want 1/23/1", full_w, addr_w, err_w);
    end
    for (int k = 0; k < 5; k++) do_cmd(0, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (addr_w !== AW'(1) || err_w !== 1'b1 || empty_w !== 1'b1) begin
      errors++;
      $display("FAIL underflow: got addr=%0d err=%b empty=%b want 1/1/1", addr_w, err_w, empty_w);
    end
    do_cmd(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (addr_w !== '0 || err_w !== 1'b0 || empty_w !== 1'b1) begin
      errors++;
      $display("FAIL clear_after_err: got addr=%0d err=%b empty=%b want 0/0/1", addr_w, err_w, empty_w);
    end
  endtask

  task automatic test_priority();
    do_cmd(0, 1, 0, 0, 1, 1, 20, 5);
    checks++;
    if (addr_w !== AW'(20) || addr_s !== AW'(20)) begin
      errors++;
      $display("FAIL prio_load: got %0d/%0d want 20", addr_w, addr_s);
    end
    do_cmd(1, 0, 1, 0, 0, 0, 50, 0);
    checks++;
    if (addr_w !== '0 || empty_w !== 1'b1) begin
      errors++;
      $display("FAIL prio_clear_call: got addr=%0d empty=%b want 0/1", addr_w, empty_w);
    end
  endtask

  task automatic test_async_reset();
    do_cmd(1, 0, 0, 0, 0, 0, 0, 0);
    do_cmd(0, 0, 1, 0, 0, 0, 30, 0);
    do_cmd(0, 0, 1, 0, 0, 0, 40, 0);
    do_cmd(0, 0, 1, 0, 0, 0, 50, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== {AW'(0), 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %h want %h", i, obs(i), {AW'(0), 4'b0100});
      end
    end
    #1;
    reset_n = 1'b1;
    do_cmd(0, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (err_w !== 1'b1 || addr_w !== '0) begin
      errors++;
      $display("FAIL ret_after_reset: got err=%b addr=%0d want 1/0", err_w, addr_w);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      set_cmd($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(118, 127)) : int'($urandom_range(0, 127)),
              int'($urandom_range(0, 127)));
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random k=%0d dut%0d: got %h want %h", k, i, obs(i), exp_vec(i));
        end
      end
    end
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_saturate();
    test_call_ret();
    test_overflow();
    test_priority();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter for the instruction-fetch path, superseding the fixed 7-bit up-counter. It is driven by the control state machine and adds absolute jumps, signed relative branches, and call/return through an internal return-address stack. Overflow is selectable: wrap-around or saturate-and-halt. Output `address` indexes instruction memory directly.

## Interface
- `ADDR_W`, 7: address width in bits (instruction memory depth 2^ADDR_W).
- `STACK_DEPTH`, 4: return-stack entries, ≥1.
- `WRAP`, 1: 1 = `up` at max address wraps to 0; 0 = saturate at max and assert `halted`.
- `RESET_ADDR`, 0: address value after reset and after `clear`.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear: address to `RESET_ADDR`, stack emptied, flags cleared.
- `up`  in  1  increment address by 1.
- `load`  in  1  absolute jump to `target`.
- `call`  in  1  push return address (`address`+1), jump to `target`.
- `ret`  in  1  pop top of stack into `address`.
- `branch`  in  1  relative jump by `offset`.
- `target`  in  ADDR_W  jump/call destination.
- `offset`  in  ADDR_W  signed two's-complement branch displacement.
- `address`  out  ADDR_W  current program counter.
- `stack_full`  out  1  stack holds `STACK_DEPTH` entries.
- `stack_empty`  out  1  stack holds 0 entries.
- `halted`  out  1  saturated at max (WRAP=0 only).
- `err`  out  1  sticky: call on full or ret on empty attempted.

## Operation
- One command executes per cycle. Fixed priority: `clear` > `load` > `call` > `ret` > `branch` > `up`. Lower-priority inputs asserted in the same cycle are ignored.
- No command asserted: all state holds.
- `load`: `address` ← `target`.
- `call`, stack not full: push (`address`+1) mod 2^ADDR_W, then `address` ← `target`.
- `call`, stack full: no push, `address` holds, `err` ← 1.
- `ret`, stack not empty: `address` ← popped entry.
- `ret`, stack empty: `address` holds, `err` ← 1.
- `branch`: `address` ← (`address` + `offset`) mod 2^ADDR_W. Wraps in both directions regardless of `WRAP`.
- `up`, `address` < max: increment.
- `up`, `address` = max, WRAP=1: `address` ← 0.
- `up`, `address` = max, WRAP=0: `address` holds, `halted` ← 1.
- While `halted`, `up` is ignored. `halted` is cleared by any executed `clear`, `load`, `call`, `ret` or `branch`.
- `err` is cleared only by `clear` or reset.
- Stack pointer `sp` ranges 0..`STACK_DEPTH`. `stack_full` = (`sp`==`STACK_DEPTH`); `stack_empty` = (`sp`==0).

## Timing
- All outputs are registered. A command sampled at edge N is visible on outputs after edge N. Latency 1 cycle, throughput 1 command/cycle.
- Back-to-back `call`/`ret` in consecutive cycles are legal. A `ret` immediately after a `call` returns the just-pushed value.
- Reset (asynchronous, `reset_n`=0) forces `address`=`RESET_ADDR`, `sp`=0, `stack_full`=0, `stack_empty`=1, `halted`=0, `err`=0, independent of `clk`. This applies mid-operation, including mid call-chain. Stack contents are don't-care after reset.
- `reset_n` deassertion is synchronous to `clk`, handled externally. The first command is accepted on the first rising edge with `reset_n`=1.
- `clear` has the same effect as reset but is synchronous and takes one cycle.

## Structure
- Shared package `pc_seq_pkg`:
  - enum `pc_cmd_t` {CMD_NONE, CMD_CLEAR, CMD_LOAD, CMD_CALL, CMD_RET, CMD_BRANCH, CMD_UP};
  - function `pc_decode` implementing the priority encoder from the six strobes.
- Sub-module `pc_return_stack`: parametrised LIFO (`ADDR_W`, `STACK_DEPTH`) with push/pop/flush, `full`/`empty`, and registered top-of-stack output. It rejects push-on-full and pop-on-empty internally and reports them on a `fault` pulse, which the top level accumulates into `err`.
- Top level: command decode, PC register, `halted`/`err` registers, adder for increment/branch.

## Test plan
- Reset, then `up` held 130 cycles (ADDR_W=7, WRAP=1) → `address` counts 0..127, then 0, 1; `halted` stays 0.
- WRAP=0, `load` target=125, then `up` ×4 → `address` 126, 127, 127, 127; `halted`=1 from the third `up`. Then `branch` offset=−2 → `address`=125, `halted`=0.
- At `address`=10: `call` target=40, then `call` target=60, then `ret`, `ret` → `address` 40, 60, 41, 11; `stack_empty`=1 at end; `err`=0.
- Five `call`s with STACK_DEPTH=4 → `stack_full`=1 after the fourth; the fifth leaves `address` unchanged and sets `err`=1. Then `ret` on an emptied stack keeps `address`, `err` stays 1. `clear` → `address`=0, `err`=0, `stack_empty`=1.
- Same cycle `load`=1 target=20, `up`=1, `branch`=1 → `address`=20. Same cycle `clear`+`call` → `address`=0, no push.
- `reset_n` pulsed low between edges during a 3-deep call chain → all outputs at reset values immediately. Next `ret` → `err`=1.
